// File: rtl/mac3_driver.sv
// Upstream controller for a 3-tap MAC: feeds operand beats into the MAC, tracks
// accumulation groups, and returns each group's captured result on a valid/ready stream.
module mac3_driver #(
  parameter int A_WIDTH           = 16,
  parameter int B_WIDTH           = 16,
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int OUTPUT_WIDTH      = 16,
  parameter int MAX_BEATS         = 64
) (
  input  logic                                clk,
  input  logic                                arst_n_in,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [A_WIDTH-1:0]           in_a0,
  input  logic signed [A_WIDTH-1:0]           in_a1,
  input  logic signed [A_WIDTH-1:0]           in_a2,
  input  logic signed [B_WIDTH-1:0]           in_b0,
  input  logic signed [B_WIDTH-1:0]           in_b1,
  input  logic signed [B_WIDTH-1:0]           in_b2,
  input  logic signed [ACCUMULATOR_WIDTH-1:0] in_psum,
  input  logic                                in_last,
  output logic                                mac_input_valid,
  output logic                                mac_accumulate_internal,
  output logic signed [ACCUMULATOR_WIDTH-1:0] mac_partial_sum_in,
  output logic signed [A_WIDTH-1:0]           mac_a0,
  output logic signed [A_WIDTH-1:0]           mac_a1,
  output logic signed [A_WIDTH-1:0]           mac_a2,
  output logic signed [B_WIDTH-1:0]           mac_b0,
  output logic signed [B_WIDTH-1:0]           mac_b1,
  output logic signed [B_WIDTH-1:0]           mac_b2,
  input  logic signed [OUTPUT_WIDTH-1:0]      mac_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [OUTPUT_WIDTH-1:0]      out_data,
  output logic [$clog2(MAX_BEATS+1)-1:0]      out_beats,
  output logic                                err_overflow
);

  localparam int CW = $clog2(MAX_BEATS+1);

  typedef enum logic {FIRST, ACCUM} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, beat_cnt;
  logic          accept, is_first, close, ovf_hit;

  logic                                vld_p1, acc_int_p1, last_p1;
  logic signed [A_WIDTH-1:0]           a0_p1, a1_p1, a2_p1;
  logic signed [B_WIDTH-1:0]           b0_p1, b1_p1, b2_p1;
  logic signed [ACCUMULATOR_WIDTH-1:0] psum_p1;
  logic [CW-1:0]                       beats_p1, beats_p2;
  logic                                vld_p2;

  // A last beat in flight blocks new beats so the result register is free at capture.
  assign in_ready = arst_n_in & ~last_p1 & ~vld_p2 & ~(out_valid & ~out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    is_first  = (state == FIRST);
    beat_cnt  = is_first ? CW'(1) : cnt + CW'(1);
    close     = in_last | (beat_cnt == CW'(MAX_BEATS));
    ovf_hit   = accept & ~in_last & (beat_cnt == CW'(MAX_BEATS));
    if (accept) begin
      cnt_nxt   = beat_cnt;
      state_nxt = close ? FIRST : ACCUM;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state        <= FIRST;
      cnt          <= '0;
      err_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ovf_hit) err_overflow <= 1'b1;
    end
  end

  // Stage p1: registered MAC drive
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      acc_int_p1 <= 1'b0;
      psum_p1    <= '0;
      a0_p1      <= '0;
      a1_p1      <= '0;
      a2_p1      <= '0;
      b0_p1      <= '0;
      b1_p1      <= '0;
      b2_p1      <= '0;
      beats_p1   <= '0;
    end else begin
      vld_p1  <= accept;
      last_p1 <= accept & close;
      if (accept) begin
        acc_int_p1 <= ~is_first;
        psum_p1    <= is_first ? in_psum : '0;
        a0_p1      <= in_a0;
        a1_p1      <= in_a1;
        a2_p1      <= in_a2;
        b0_p1      <= in_b0;
        b1_p1      <= in_b1;
        b2_p1      <= in_b2;
        beats_p1   <= beat_cnt;
      end
    end
  end

  assign mac_input_valid         = vld_p1;
  assign mac_accumulate_internal = acc_int_p1;
  assign mac_partial_sum_in      = psum_p1;
  assign mac_a0                  = a0_p1;
  assign mac_a1                  = a1_p1;
  assign mac_a2                  = a2_p1;
  assign mac_b0                  = b0_p1;
  assign mac_b1                  = b1_p1;
  assign mac_b2                  = b2_p1;

  // Stage p2: MAC accumulator settles; mac_out is captured at the end of this stage
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      vld_p2   <= 1'b0;
      beats_p2 <= '0;
    end else begin
      vld_p2   <= last_p1;
      beats_p2 <= beats_p1;
    end
  end

  // Result register: holds until the downstream handshake completes
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
    end else if (vld_p2) begin
      out_valid <= 1'b1;
      out_data  <= mac_out;
      out_beats <= beats_p2;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac3_driver.sv
// Directed testbench for mac3_driver with a behavioural 3-tap MAC attached to its drive pins.
module tb_mac3_driver;

  localparam int AW  = 16;
  localparam int BW  = 16;
  localparam int ACW = 32;
  localparam int OW  = 16;
  localparam int MB  = 4;
  localparam int CW  = $clog2(MB+1);

  logic                  clk = 1'b0;
  logic                  arst_n_in;
  logic                  in_valid, in_ready, in_last;
  logic signed [AW-1:0]  in_a0, in_a1, in_a2;
  logic signed [BW-1:0]  in_b0, in_b1, in_b2;
  logic signed [ACW-1:0] in_psum;
  logic                  mac_input_valid, mac_accumulate_internal;
  logic signed [ACW-1:0] mac_partial_sum_in;
  logic signed [AW-1:0]  mac_a0, mac_a1, mac_a2;
  logic signed [BW-1:0]  mac_b0, mac_b1, mac_b2;
  logic signed [OW-1:0]  mac_out;
  logic                  out_valid, out_ready;
  logic signed [OW-1:0]  out_data;
  logic [CW-1:0]         out_beats;
  logic                  err_overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac3_driver #(
    .A_WIDTH(AW), .B_WIDTH(BW), .ACCUMULATOR_WIDTH(ACW),
    .OUTPUT_WIDTH(OW), .MAX_BEATS(MB)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_a2(in_a2),
    .in_b0(in_b0), .in_b1(in_b1), .in_b2(in_b2),
    .in_psum(in_psum), .in_last(in_last),
    .mac_input_valid(mac_input_valid),
    .mac_accumulate_internal(mac_accumulate_internal),
    .mac_partial_sum_in(mac_partial_sum_in),
    .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_a2(mac_a2),
    .mac_b0(mac_b0), .mac_b1(mac_b1), .mac_b2(mac_b2),
    .mac_out(mac_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_beats(out_beats),
    .err_overflow(err_overflow)
  );

  // Behavioural MAC: registered accumulator, no output scaling
  logic signed [ACW-1:0] acc = '0;
  always @(posedge clk) begin
    if (mac_input_valid)
      acc <= (mac_accumulate_internal ? acc : mac_partial_sum_in)
             + mac_a0 * mac_b0 + mac_a1 * mac_b1 + mac_a2 * mac_b2;
  end
  assign mac_out = acc[OW-1:0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns one step after it is accepted (S1 visible).
  task automatic send_beat(input logic signed [AW-1:0] a0, a1, a2,
                           input logic signed [BW-1:0] b0, b1, b2,
                           input logic signed [ACW-1:0] psum, input logic last);
    int n;
    in_a0 = a0; in_a1 = a1; in_a2 = a2;
    in_b0 = b0; in_b1 = b1; in_b2 = b2;
    in_psum = psum; in_last = last; in_valid = 1'b1;
    #0;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      failures++;
      $display("FAIL send_beat_timeout in_ready=%0b required=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    arst_n_in = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_a0 = '0; in_a1 = '0; in_a2 = '0; in_b0 = '0; in_b1 = '0; in_b2 = '0; in_psum = '0;
    #12;
    checks++;
    if ({in_ready, mac_input_valid, out_valid, err_overflow} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b required=0000",
               {in_ready, mac_input_valid, out_valid, err_overflow});
    end
    checks++;
    if (out_data !== 16'sd0 || out_beats !== 3'd0 || mac_partial_sum_in !== 32'sd0) begin
      failures++;
      $display("FAIL reset_data out_data=%0d out_beats=%0d psum=%0d required=0",
               out_data, out_beats, mac_partial_sum_in);
    end
    @(negedge clk);
    arst_n_in = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b required=1", in_ready);
    end
  endtask

  task automatic test_single_beat();
    send_beat(1, 2, 3, 4, 5, 6, 10, 1'b1);
    checks++;
    if (mac_input_valid !== 1'b1 || mac_accumulate_internal !== 1'b0 ||
        mac_partial_sum_in !== 32'sd10) begin
      failures++;
      $display("FAIL single_s1 vld=%b acc_int=%b psum=%0d required 1/0/10",
               mac_input_valid, mac_accumulate_internal, mac_partial_sum_in);
    end
    checks++;
    if (mac_a2 !== 16'sd3 || mac_b1 !== 16'sd5) begin
      failures++;
      $display("FAIL single_operands a2=%0d b1=%0d required 3/5", mac_a2, mac_b1);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || mac_input_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early out_valid=%b mac_vld=%b required 0/0",
               out_valid, mac_input_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd42 || out_beats !== 3'd1) begin
      failures++;
      $display("FAIL single_result valid=%b data=%0d beats=%0d required 1/42/1",
               out_valid, out_data, out_beats);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drop got=%b required=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] acc_int;
    send_beat(1, 1, 1, 1, 1, 1, 0, 1'b0);
    acc_int[0] = mac_accumulate_internal;
    send_beat(1, 1, 1, 1, 1, 1, 0, 1'b0);
    acc_int[1] = mac_accumulate_internal;
    send_beat(1, 1, 1, 1, 1, 1, 0, 1'b1);
    acc_int[2] = mac_accumulate_internal;
    checks++;
    if (acc_int !== 3'b110) begin
      failures++;
      $display("FAIL b2b_acc_int got=%b required=110 (beat2..beat0)", acc_int);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready_t1 got=%b required=0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready_t2 got=%b required=0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd9 || out_beats !== 3'd3 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_result valid=%b data=%0d beats=%0d ready=%b required 1/9/3/1",
               out_valid, out_data, out_beats, in_ready);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int bad;
    out_ready = 1'b0;
    send_beat(1, 0, 0, 5, 0, 0, 0, 1'b1);
    tick();
    tick();
    in_a0 = 7; in_b0 = 1; in_a1 = 0; in_b1 = 0; in_a2 = 0; in_b2 = 0;
    in_psum = 0; in_last = 1'b1; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #0;
      if (out_valid !== 1'b1 || out_data !== 16'sd5 || in_ready !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold bad_cycles=%0d required=0 (valid=%b data=%0d ready=%b)",
               bad, out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_data !== 16'sd5) begin
      failures++;
      $display("FAIL bp_release ready=%b data=%0d required 1/5", in_ready, out_data);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || mac_input_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_handoff out_valid=%b mac_vld=%b required 0/1", out_valid, mac_input_valid);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd7 || out_beats !== 3'd1) begin
      failures++;
      $display("FAIL bp_second valid=%b data=%0d beats=%0d required 1/7/1",
               out_valid, out_data, out_beats);
    end
    tick();
  endtask

  task automatic test_signed();
    send_beat(-3, 0, 0, 4, 0, 0, -8, 1'b1);
    checks++;
    if (mac_a0 !== -16'sd3 || mac_partial_sum_in !== -32'sd8) begin
      failures++;
      $display("FAIL signed_s1 a0=%0d psum=%0d required -3/-8", mac_a0, mac_partial_sum_in);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hFFEC) begin
      failures++;
      $display("FAIL signed_result valid=%b data=%h required 1/ffec", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_overflow();
    checks++;
    if (err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pre got=%b required=0", err_overflow);
    end
    for (int i = 0; i < 3; i++) send_beat(1, 1, 1, 1, 1, 1, 0, 1'b0);
    checks++;
    if (err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_beat3 got=%b required=0", err_overflow);
    end
    send_beat(1, 1, 1, 1, 1, 1, 0, 1'b0);
    checks++;
    if (err_overflow !== 1'b1 || mac_accumulate_internal !== 1'b1) begin
      failures++;
      $display("FAIL ovf_beat4 err=%b acc_int=%b required 1/1", err_overflow, mac_accumulate_internal);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_beats !== 3'd4 || out_data !== 16'sd12) begin
      failures++;
      $display("FAIL ovf_result valid=%b beats=%0d data=%0d required 1/4/12",
               out_valid, out_beats, out_data);
    end
    send_beat(1, 1, 1, 1, 1, 1, 0, 1'b0);
    checks++;
    if (mac_accumulate_internal !== 1'b0 || err_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_beat5 acc_int=%b err=%b required 0/1", mac_accumulate_internal, err_overflow);
    end
    send_beat(1, 1, 1, 1, 1, 1, 0, 1'b1);
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_beats !== 3'd2 || out_data !== 16'sd6) begin
      failures++;
      $display("FAIL ovf_next_group valid=%b beats=%0d data=%0d required 1/2/6",
               out_valid, out_beats, out_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_group();
    send_beat(1, 1, 1, 1, 1, 1, 100, 1'b0);
    send_beat(1, 1, 1, 1, 1, 1, 100, 1'b0);
    #2;
    arst_n_in = 1'b0;
    #1;
    checks++;
    if ({mac_input_valid, mac_accumulate_internal, in_ready, err_overflow, out_valid} !== 5'b00000 ||
        mac_a0 !== 16'sd0 || mac_partial_sum_in !== 32'sd0 || out_beats !== 3'd0) begin
      failures++;
      $display("FAIL midreset_clear flags=%b a0=%0d psum=%0d beats=%0d required all 0",
               {mac_input_valid, mac_accumulate_internal, in_ready, err_overflow, out_valid},
               mac_a0, mac_partial_sum_in, out_beats);
    end
    @(negedge clk);
    @(negedge clk);
    arst_n_in = 1'b1;
    tick();
    send_beat(2, 0, 0, 3, 0, 0, 1, 1'b1);
    checks++;
    if (mac_accumulate_internal !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_first acc_int=%b out_valid=%b required 0/0",
               mac_accumulate_internal, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_stale got=%b required=0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd7 || out_beats !== 3'd1) begin
      failures++;
      $display("FAIL midreset_result valid=%b data=%0d beats=%0d required 1/7/1",
               out_valid, out_data, out_beats);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_backpressure();
    test_signed();
    test_overflow();
    test_reset_mid_group();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim_time=%0t required=finish", $time);
    $fatal(1);
  end

endmodule
